// File: rtl/hwpe_stream_burst_rr_arbiter_if.sv
// HWPE-Stream handshake bundle.
//   valid/data/strb : producer -> consumer
//   ready           : consumer -> producer
// master = producer side, slave = consumer side.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/hwpe_stream_burst_rr_arbiter.sv
// Round-robin arbiter with burst locking onto one shared HWPE-Stream sink.
// A granted requester keeps the output for len_q accepted beats so its
// bursts are never interleaved; a starvation timeout releases a requester
// that drops valid mid-burst. valid/data/strb are combinational from the
// selected input (zero latency).
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clear_i        synchronous soft clear (highest priority)
//   burst_len_i    beats per grant, 0 behaves as 1
//   push_i[NB_IN]  requester streams (slave)
//   pop_o          shared output stream (master)
//   grant_o        one-hot current grant, zero when nothing selected
//   busy_o         high while a burst lock is held
//   timeout_o      one-cycle pulse after a lock is released by timeout
module hwpe_stream_burst_rr_arbiter #(
  parameter int unsigned NB_IN           = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [BURST_LEN_WIDTH-1:0] burst_len_i,
  hwpe_stream_intf_stream.slave      push_i [NB_IN],
  hwpe_stream_intf_stream.master     pop_o,
  output logic [NB_IN-1:0]           grant_o,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int unsigned IDX_W   = $clog2(NB_IN);
  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned IDLE_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // flattened views of the requester interfaces
  logic [NB_IN-1:0]                 in_valid;
  logic [NB_IN-1:0]                 in_ready;
  logic [NB_IN-1:0][DATA_WIDTH-1:0] in_data;
  logic [NB_IN-1:0][STRB_W-1:0]     in_strb;

  for (genvar g = 0; g < NB_IN; g++) begin : g_lane
    assign in_valid[g]    = push_i[g].valid;
    assign in_data[g]     = push_i[g].data;
    assign in_strb[g]     = push_i[g].strb;
    assign push_i[g].ready = in_ready[g];
  end

  logic [0:0]                 state;
  logic [IDX_W-1:0]           rr_ptr;
  logic [IDX_W-1:0]           lock_idx;
  logic [BURST_LEN_WIDTH-1:0] beat_cnt;
  logic [BURST_LEN_WIDTH-1:0] len_q;
  logic [IDLE_W-1:0]          idle_cnt;
  logic                       timeout_q;

  // first valid requester searching from rr_ptr; iterating downward lets
  // the closest candidate overwrite farther ones without a break
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W:0]   cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NB_IN - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NB_IN)) cand = cand - (IDX_W+1)'(NB_IN);
      if (in_valid[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  logic             locked;
  logic             active;
  logic [IDX_W-1:0] cur_idx;
  logic             hs;

  assign locked  = (state == ST_LOCKED);
  assign active  = locked | sel_found;
  assign cur_idx = locked ? lock_idx : sel_idx;

  always_comb begin
    grant_o = '0;
    if (active) grant_o[cur_idx] = 1'b1;
  end

  assign pop_o.valid = active & in_valid[cur_idx];
  assign pop_o.data  = in_data[cur_idx];
  assign pop_o.strb  = in_strb[cur_idx];
  assign in_ready    = grant_o & {NB_IN{pop_o.ready}};
  assign hs          = pop_o.valid & pop_o.ready;

  assign busy_o    = locked;
  assign timeout_o = timeout_q;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NB_IN - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  logic [BURST_LEN_WIDTH-1:0] len_eff;
  logic                       last_beat;
  logic                       starve_hit;

  assign len_eff    = (burst_len_i == '0) ? BURST_LEN_WIDTH'(1) : burst_len_i;
  assign last_beat  = (beat_cnt == len_q - BURST_LEN_WIDTH'(1));
  assign starve_hit = (TIMEOUT_CYCLES > 0) && (idle_cnt == IDLE_W'(TO_LAST));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      lock_idx  <= '0;
      beat_cnt  <= '0;
      len_q     <= '0;
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (clear_i) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      lock_idx  <= '0;
      beat_cnt  <= '0;
      len_q     <= '0;
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (!locked) begin
        if (hs) begin
          len_q    <= len_eff;
          lock_idx <= sel_idx;
          if (len_eff == BURST_LEN_WIDTH'(1)) begin
            rr_ptr <= wrap_inc(sel_idx);
          end else begin
            state    <= ST_LOCKED;
            beat_cnt <= BURST_LEN_WIDTH'(1);
            idle_cnt <= '0;
          end
        end
      end else if (hs) begin
        idle_cnt <= '0;
        if (last_beat) begin
          state    <= ST_IDLE;
          rr_ptr   <= wrap_inc(lock_idx);
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + BURST_LEN_WIDTH'(1);
        end
      end else if (!in_valid[lock_idx]) begin
        // only an absent requester counts as idle; backpressure holds
        if (starve_hit) begin
          state     <= ST_IDLE;
          rr_ptr    <= wrap_inc(lock_idx);
          beat_cnt  <= '0;
          idle_cnt  <= '0;
          timeout_q <= 1'b1;
        end else if (idle_cnt != '1) begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hwpe_stream_burst_rr_arbiter.sv
module tb_hwpe_stream_burst_rr_arbiter;
  localparam int NB = 4;
  localparam int DW = 32;
  localparam int BLW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic [BLW-1:0] burst_len = '0;
  logic [NB-1:0] grant;
  logic busy, timeout;

  logic [NB-1:0]          tb_valid = '0;
  logic [NB-1:0]          tb_ready;
  logic [NB-1:0][DW-1:0]  tb_data;
  logic [NB-1:0][DW/8-1:0] tb_strb;
  logic                   pop_ready = 1'b1;
  int                     seq [NB];
  logic [NB-1:0]          acc = '0;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if [NB] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop_if ();

  for (genvar g = 0; g < NB; g++) begin : g_drv
    assign push_if[g].valid = tb_valid[g];
    assign push_if[g].data  = tb_data[g];
    assign push_if[g].strb  = tb_strb[g];
    assign tb_ready[g]      = push_if[g].ready;
  end
  assign pop_if.ready = pop_ready;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      tb_data[i] = {8'(i), 24'(seq[i])};
      tb_strb[i] = 4'(i + 1);
    end
  end

  hwpe_stream_burst_rr_arbiter #(
    .NB_IN(NB), .DATA_WIDTH(DW), .BURST_LEN_WIDTH(BLW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .burst_len_i(burst_len),
    .push_i(push_if), .pop_o(pop_if),
    .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the output, how many beats it still owes, where the
  // next search starts, and how long the owner has been absent.
  int m_owner = -1, m_left = 0, m_next = 0, m_dry = 0;
  logic m_pulse = 1'b0;
  int n_owner, n_left, n_next, n_dry;
  logic n_pulse;

  logic [DW-1:0] out_q [$];
  logic          busy_q [$];
  int            busy_cnt = 0;
  int            to_cnt = 0;

  always @(negedge clk) begin
    int eg, j, L;
    logic [NB-1:0] eg_oh;
    logic e_valid, e_hs;
    eg = -1;
    if (m_owner >= 0) eg = m_owner;
    else
      for (int k = 0; k < NB; k++) begin
        j = (m_next + k) % NB;
        if (eg < 0 && tb_valid[j]) eg = j;
      end
    eg_oh   = (eg >= 0) ? (NB'(1) << eg) : '0;
    e_valid = (eg >= 0) && tb_valid[eg];
    chk("grant", 64'(grant), 64'(eg_oh));
    chk("busy", 64'(busy), 64'(m_owner >= 0));
    chk("timeout", 64'(timeout), 64'(m_pulse));
    chk("pop_valid", 64'(pop_if.valid), 64'(e_valid));
    chk("push_ready", 64'(tb_ready), 64'(eg_oh & {NB{pop_ready}}));
    if (e_valid) begin
      chk("pop_data", 64'(pop_if.data), 64'(tb_data[eg]));
      chk("pop_strb", 64'(pop_if.strb), 64'(tb_strb[eg]));
    end
    if (pop_if.valid && pop_ready) begin
      out_q.push_back(pop_if.data);
      busy_q.push_back(busy);
    end
    busy_cnt += int'(busy);
    to_cnt   += int'(timeout);
    acc = tb_valid & tb_ready;

    e_hs = e_valid && pop_ready;
    n_owner = m_owner; n_left = m_left; n_next = m_next; n_dry = m_dry; n_pulse = 1'b0;
    if (clear) begin
      n_owner = -1; n_left = 0; n_next = 0; n_dry = 0;
    end else if (m_owner < 0) begin
      if (e_hs) begin
        L = (burst_len == 0) ? 1 : int'(burst_len);
        if (L == 1) n_next = (eg + 1) % NB;
        else begin n_owner = eg; n_left = L - 1; n_dry = 0; end
      end
    end else if (e_hs) begin
      n_left = m_left - 1; n_dry = 0;
      if (n_left == 0) begin n_owner = -1; n_next = (eg + 1) % NB; end
    end else if (!tb_valid[eg]) begin
      n_dry = m_dry + 1;
      if (TO > 0 && n_dry >= TO) begin
        n_owner = -1; n_next = (eg + 1) % NB; n_dry = 0; n_pulse = 1'b1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_left <= 0; m_next <= 0; m_dry <= 0; m_pulse <= 1'b0;
    end else begin
      m_owner <= n_owner; m_left <= n_left; m_next <= n_next;
      m_dry <= n_dry; m_pulse <= n_pulse;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) if (acc[i]) seq[i]++;
  endtask

  task automatic wait_beats(input int n);
    int c;
    c = 0;
    while (out_q.size() < n && c < 300) begin tick(); c++; end
    chk("beats_reached", 64'(out_q.size() >= n), 64'd1);
  endtask

  task automatic begin_test();
    tb_valid = '0; pop_ready = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < NB; i++) seq[i] = 0;
    out_q.delete(); busy_q.delete();
    busy_cnt = 0; to_cnt = 0;
  endtask

  initial begin
    int idle;
    for (int i = 0; i < NB; i++) seq[i] = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_pop_valid", 64'(pop_if.valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // round-robin bursts of 3
    begin_test();
    burst_len = 8'd3; tb_valid = '1;
    wait_beats(13);
    tb_valid = '0;
    for (int k = 0; k < 13; k++) begin
      chk("rr_tag", 64'(out_q[k][31:24]), 64'((k / 3) % 4));
      chk("rr_busy", 64'(busy_q[k]), 64'((k % 3) != 0));
    end
    chk("rr_seq_in1", 64'(out_q[4][23:0]), 64'd1);

    // backpressure mid-burst
    begin_test();
    burst_len = 8'd4; tb_valid = 4'b0100;
    wait_beats(2);
    pop_ready = 1'b0;
    repeat (5) tick();
    pop_ready = 1'b1;
    wait_beats(4);
    tb_valid = 4'b1010;
    @(negedge clk);
    chk("bp_no_timeout", 64'(to_cnt), 64'd0);
    chk("bp_beats_tag", 64'({out_q[2][31:24], out_q[3][31:24]}), 64'h0202);
    chk("bp_next_grant", 64'(grant), 64'b1000);
    tb_valid = '0;

    // starvation timeout
    begin_test();
    burst_len = 8'd8; tb_valid = 4'b0010;
    wait_beats(2);
    tb_valid = 4'b1000;
    idle = 0;
    @(negedge clk);
    while (!timeout && idle < 40) begin idle++; @(negedge clk); end
    chk("to_idle_cycles", 64'(idle), 64'd16);
    chk("to_grant", 64'(grant), 64'b1000);
    chk("to_tag", 64'(pop_if.data[31:24]), 64'd3);
    tick();
    tb_valid = '0;

    // burst_len 0 then 1: strict alternation, never busy
    begin_test();
    burst_len = 8'd0; tb_valid = 4'b0101;
    wait_beats(4);
    burst_len = 8'd1;
    wait_beats(8);
    tb_valid = '0;
    for (int k = 0; k < 8; k++) chk("alt_tag", 64'(out_q[k][31:24]), 64'((k % 2) * 2));
    chk("alt_busy", 64'(busy_cnt), 64'd0);

    // clear at beat 2 of a 5-beat burst from input 1
    begin_test();
    burst_len = 8'd5; tb_valid = 4'b0010;
    wait_beats(1);
    clear = 1'b1; tb_valid = 4'b0011;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_grant", 64'(grant), 64'b0001);
    chk("clr_busy", 64'(busy), 64'd0);
    wait_beats(3);
    tb_valid = '0;
    chk("clr_beat0", 64'(out_q[0]), 64'h01000000);
    chk("clr_beat1", 64'(out_q[1]), 64'h01000001);
    chk("clr_beat2", 64'(out_q[2]), 64'h00000000);

    // async reset while locked
    begin_test();
    burst_len = 8'd4; tb_valid = 4'b0100;
    wait_beats(2);
    #2;
    tb_valid = '0; rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_grant", 64'(grant), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1; tb_valid = 4'b0101;
    @(negedge clk);
    chk("ar_restart_grant", 64'(grant), 64'b0001);
    tick();
    tb_valid = '0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end
endmodule
